swap_reg_slave: RTL and testbench

Sequential bus slave that sits directly downstream of the aggregate bus master, on the slv_* side of the master/slave link. It holds a 16-entry x 4-bit register array. Every accepted transaction is an atomic swap: it returns the old contents of the addressed entry on slv_rdata and writes slv_wdata into that entry. A programmable wait-state FSM sets how long slv_ready is delayed, and a 5-bit transaction counter is exported on bus_out.

---
 rtl/swap_reg_slave.sv | 98 +++++++++
 tb/tb_swap_reg_slave.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/swap_reg_slave.sv
// Bus slave holding a 2**ADDR_W x DATA_W register array; every accepted request
// atomically swaps the addressed entry with the request data after WAIT_CYCLES wait states.
module swap_reg_slave #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              slv_valid,
    input  logic [ADDR_W-1:0] slv_addr,
    input  logic [DATA_W-1:0] slv_wdata,
    output logic [DATA_W-1:0] slv_rdata,
    output logic              slv_ready,
    output logic [4:0]        bus_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [2:0]          wait_cnt_reg, wait_cnt_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [DATA_W-1:0]   mem_reg [DEPTH];

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (slv_valid) begin
                    addr_next  = slv_addr;
                    wdata_next = slv_wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = 3'(WAIT_CYCLES);
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == 3'd1) begin
                    state_next = ST_RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 3'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Response registers load on entry to RESP so ready/rdata line up with the RESP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            slv_ready    <= 1'b0;
            slv_rdata    <= '0;
            bus_out      <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            slv_ready    <= (state_next == ST_RESP);
            if (state_next == ST_RESP) begin
                slv_rdata <= mem_reg[addr_next];
            end
            if (state_reg == ST_RESP) begin
                bus_out <= bus_out + 5'd1;
            end
        end
    end

    // Write lands at the end of RESP, so the read above always sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (state_reg == ST_RESP) begin
            mem_reg[addr_reg] <= wdata_reg;
        end
    end

endmodule

// File: tb/tb_swap_reg_slave.sv
// Self-checking bench for swap_reg_slave: directed table, random swaps vs. a plain
// array model, streaming, reset mid-transaction, and a zero-wait-state instance.
module tb_swap_reg_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       slv_valid, slv_ready;
    logic [3:0] slv_addr, slv_wdata, slv_rdata;
    logic [4:0] bus_out;
    logic       valid0, ready0;
    logic [3:0] addr0, wdata0, rdata0;
    logic [4:0] bus0;

    int n_pass  = 0;
    int n_total = 0;
    int model_mem [16];
    int model_cnt;

    always #5 clk = ~clk;

    swap_reg_slave #(.WAIT_CYCLES(2), .ADDR_W(4), .DATA_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .slv_valid(slv_valid), .slv_addr(slv_addr),
        .slv_wdata(slv_wdata), .slv_rdata(slv_rdata), .slv_ready(slv_ready), .bus_out(bus_out)
    );

    swap_reg_slave #(.WAIT_CYCLES(0), .ADDR_W(4), .DATA_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .slv_valid(valid0), .slv_addr(addr0),
        .slv_wdata(wdata0), .slv_rdata(rdata0), .slv_ready(ready0), .bus_out(bus0)
    );

    typedef struct {
        logic [3:0] addr;
        logic [3:0] wdata;
        int         exp_rdata;
        int         exp_count;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = 0;
        model_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        slv_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One pulsed request; inputs are scrambled while waiting to prove they are ignored.
    task automatic swap(input logic [3:0] a, input logic [3:0] w,
                        output int rd, output int lat, output int cnt_after, output int rdy_after);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        rd   = -1;
        @(negedge clk);
        slv_valid = 1'b1;
        slv_addr  = a;
        slv_wdata = w;
        @(posedge clk);
        while (!seen && lat < 20) begin
            @(negedge clk);
            slv_valid = 1'b0;
            slv_addr  = 4'($urandom);
            slv_wdata = 4'($urandom);
            lat++;
            if (slv_ready) begin
                seen = 1'b1;
                rd   = int'(slv_rdata);
            end
        end
        if (!seen) lat = -1;
        @(negedge clk);
        cnt_after = int'(bus_out);
        rdy_after = int'(slv_ready);
        $display("txn addr=%0h wdata=%0h rdata=%0h latency=%0d bus_out=%0d", a, w, rd, lat, cnt_after);
    endtask

    initial begin
        vec_t vecs [8];
        int rd, lat, cnt, rdy;

        vecs[0] = '{4'h3, 4'hA, 'h0, 1};
        vecs[1] = '{4'h3, 4'h5, 'hA, 2};
        vecs[2] = '{4'h3, 4'h1, 'h5, 3};
        vecs[3] = '{4'h0, 4'hF, 'h0, 4};
        vecs[4] = '{4'hF, 4'h7, 'h0, 5};
        vecs[5] = '{4'h0, 4'h2, 'hF, 6};
        vecs[6] = '{4'hF, 4'h0, 'h7, 7};
        vecs[7] = '{4'h3, 4'h3, 'h1, 8};

        rst_n = 1'b0;
        slv_valid = 1'b0; slv_addr = '0; slv_wdata = '0;
        valid0 = 1'b0; addr0 = '0; wdata0 = '0;
        model_reset();

        // Reset held with random traffic, then idle after release.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            slv_valid = 1'($urandom); slv_addr = 4'($urandom); slv_wdata = 4'($urandom);
            chk("reset ready", int'(slv_ready), 0);
            chk("reset rdata", int'(slv_rdata), 0);
            chk("reset bus_out", int'(bus_out), 0);
        end
        slv_valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle outputs", int'({slv_ready, slv_rdata, bus_out}), 0);
        end

        // Directed table: repeated swaps at one address and a few others.
        for (int i = 0; i < 8; i++) begin
            swap(vecs[i].addr, vecs[i].wdata, rd, lat, cnt, rdy);
            chk("table latency", lat, 3);
            chk("table rdata", rd, vecs[i].exp_rdata);
            chk("table bus_out", cnt, vecs[i].exp_count);
            chk("table ready pulse", rdy, 0);
            model_mem[vecs[i].addr] = int'(vecs[i].wdata);
            model_cnt = (model_cnt + 1) % 32;
        end

        // Random swaps against the array model.
        for (int i = 0; i < 30; i++) begin
            logic [3:0] a, w;
            int exp_rd;
            a = 4'($urandom_range(0, 5));
            w = 4'($urandom);
            exp_rd = model_mem[a];
            model_mem[a] = int'(w);
            model_cnt = (model_cnt + 1) % 32;
            swap(a, w, rd, lat, cnt, rdy);
            chk("rand latency", lat, 3);
            chk("rand rdata", rd, exp_rd);
            chk("rand bus_out", cnt, model_cnt);
        end

        // Streaming with valid held high; bus_out wraps after 32 responses.
        do_reset();
        begin
            int resp_n, last_cyc, cyc;
            resp_n = 0; last_cyc = 0; cyc = 0;
            @(negedge clk);
            slv_valid = 1'b1; slv_addr = 4'hC; slv_wdata = 4'hC;
            while (resp_n < 32 && cyc < 300) begin
                @(negedge clk);
                cyc++;
                if (slv_ready) begin
                    resp_n++;
                    if (resp_n > 1) chk("stream interval", cyc - last_cyc, 4);
                    chk("stream rdata", int'(slv_rdata), (resp_n == 1) ? 0 : 'hC);
                    chk("stream bus_out", int'(bus_out), resp_n - 1);
                    last_cyc = cyc;
                end
            end
            chk("stream responses", resp_n, 32);
            @(negedge clk);
            slv_valid = 1'b0;
            chk("stream wrap", int'(bus_out), 0);
            $display("txn stream responses=%0d bus_out=%0d", resp_n, bus_out);
        end

        // Reset during WAIT discards the pending swap.
        do_reset();
        @(negedge clk);
        slv_valid = 1'b1; slv_addr = 4'h7; slv_wdata = 4'hF;
        @(posedge clk);
        @(negedge clk);
        slv_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset ready", int'(slv_ready), 0);
        chk("midreset bus_out", int'(bus_out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        begin
            int saw;
            saw = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (slv_ready) saw++;
            end
            chk("midreset no pulse", saw, 0);
        end
        swap(4'h7, 4'h3, rd, lat, cnt, rdy);
        chk("post reset rdata", rd, 0);
        chk("post reset bus_out", cnt, 1);

        // Zero-wait instance: valid held, inputs change every cycle.
        begin
            int m0 [16];
            int c0, pa, pw;
            bit expect_resp;
            logic [3:0] a, w;
            for (int i = 0; i < 16; i++) m0[i] = 0;
            c0 = 0; pa = 0; pw = 0; expect_resp = 1'b0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                a = 4'($urandom_range(0, 3));
                w = 4'($urandom);
                if (expect_resp) begin
                    chk("w0 ready", int'(ready0), 1);
                    chk("w0 rdata", int'(rdata0), m0[pa]);
                    $display("txn w0 addr=%0h wdata=%0h rdata=%0h", pa, pw, rdata0);
                    m0[pa] = pw;
                    c0 = (c0 + 1) % 32;
                    expect_resp = 1'b0;
                end else begin
                    if (k > 0) begin
                        chk("w0 idle ready", int'(ready0), 0);
                        chk("w0 bus_out", int'(bus0), c0);
                    end
                    pa = int'(a); pw = int'(w);
                    expect_resp = 1'b1;
                end
                valid0 = 1'b1; addr0 = a; wdata0 = w;
            end
            @(negedge clk);
            valid0 = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
